// File: rtl/ddram.sv
// General Sound 2 MB window onto the DDRAM Avalon port.
// Byte-wide reads are served from a one-line 64-bit read cache.
module ddram (
  input  logic        DDRAM_CLK,
  input  logic        RESET_N,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [63:0] line;
  logic [17:0] tag;
  logic        valid;
  logic [20:0] last_addr;
  logic        last_rd;
  logic        last_we;
  logic        req_q;

  logic        req;
  logic        new_req;
  logic        hit;
  logic [5:0]  lane_bit;
  logic [5:0]  fill_bit;
  logic [28:0] word_addr;

  assign req       = rd | we;
  assign hit       = valid && (tag == addr[20:3]);
  assign lane_bit  = {addr[2:0], 3'b000};
  assign fill_bit  = {last_addr[2:0], 3'b000};
  assign word_addr = {8'h30, 3'b000, addr[20:3]};

  assign DDRAM_BURSTCNT = 8'd1;

  // A request is new if it differs from the last accepted one or re-rises.
  assign new_req = req &&
    (({addr, rd, we} != {last_addr, last_rd, last_we}) || !req_q);

  always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (new_req) begin
          if (we) begin
            state_nx = WR_WAIT;
          end else if (!hit) begin
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          state_nx = IDLE;
        end
      end
      WR_WAIT: begin
        if (!DDRAM_BUSY) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) && !new_req;
  end

  always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_BE   <= 8'h00;
      DDRAM_DIN  <= 64'h0;
      DDRAM_ADDR <= 29'h0;
      dout       <= 8'hFF;
      line       <= 64'h0;
      tag        <= 18'h0;
      valid      <= 1'b0;
      last_addr  <= 21'h0;
      last_rd    <= 1'b0;
      last_we    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        req_q <= req;
      end
      unique case (state)
        IDLE: begin
          if (new_req) begin
            last_addr <= addr;
            last_rd   <= rd;
            last_we   <= we;
            if (we) begin
              DDRAM_WE   <= 1'b1;
              DDRAM_ADDR <= word_addr;
              DDRAM_DIN  <= {8{din}};
              DDRAM_BE   <= 8'd1 << addr[2:0];
              if (hit) begin
                line[lane_bit +: 8] <= din;
              end
            end else if (hit) begin
              dout <= line[lane_bit +: 8];
            end else begin
              DDRAM_RD   <= 1'b1;
              DDRAM_ADDR <= word_addr;
            end
          end
        end
        RD_WAIT: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
          end
          if (DDRAM_DOUT_READY) begin
            DDRAM_RD <= 1'b0;
            line     <= DDRAM_DOUT;
            tag      <= last_addr[20:3];
            valid    <= 1'b1;
            dout     <= DDRAM_DOUT[fill_bit +: 8];
          end
        end
        WR_WAIT: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram.sv
// Bench for ddram: DDRAM slave model, shadow memory and
// cache-state model feeding read/write scoreboards.
module tb_ddram;

  logic        clk;
  logic        rst_n;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        we;
  logic        ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  ddram dut (
    .DDRAM_CLK(clk),
    .RESET_N(rst_n),
    .addr(addr),
    .din(din),
    .dout(dout),
    .rd(rd),
    .we(we),
    .ready(ready),
    .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE),
    .DDRAM_WE(DDRAM_WE)
  );

  int errs = 0;
  int checks = 0;

  logic [7:0]   exp_q[$];
  logic [100:0] wr_q[$];

  logic [63:0] mem[int];
  logic [63:0] shadow[int];
  int          rd_cmds = 0;
  int          wr_cmds = 0;
  int          pend = 0;
  logic [28:0] rd_word = 29'h0;
  bit          c_valid = 0;
  logic [17:0] c_tag = 18'h0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tg,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tg, got, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [17:0] w);
    return 64'h8877665544332211 ^ {8{w[7:0]}};
  endfunction

  function automatic logic [63:0] mem_get(input logic [17:0] w);
    if (mem.exists(int'(w))) return mem[int'(w)];
    return init_word(w);
  endfunction

  function automatic logic [63:0] sh_get(input logic [17:0] w);
    if (shadow.exists(int'(w))) return shadow[int'(w)];
    return init_word(w);
  endfunction

  // Avalon slave: 3-cycle read latency, writes merged by byte enable.
  initial begin
    logic [63:0] w;
    DDRAM_DOUT_READY = 0;
    DDRAM_DOUT = 64'h0;
    forever begin
      @(posedge clk);
      if (DDRAM_RD && DDRAM_WE) check("rd_we_excl", 1, 0);
      if (rst_n && DDRAM_RD && !DDRAM_BUSY) begin
        rd_cmds++;
        rd_word = DDRAM_ADDR;
        pend = 3;
      end
      if (rst_n && DDRAM_WE && !DDRAM_BUSY) begin
        wr_cmds++;
        w = mem_get(DDRAM_ADDR[17:0]);
        for (int i = 0; i < 8; i++)
          if (DDRAM_BE[i]) w[i*8 +: 8] = DDRAM_DIN[i*8 +: 8];
        mem[int'(DDRAM_ADDR[17:0])] = w;
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          DDRAM_DOUT_READY = 1;
          DDRAM_DOUT = mem_get(rd_word[17:0]);
        end
      end
    end
  end

  task automatic do_read(input logic [20:0] a);
    bit miss;
    int n;
    int r0;
    logic [63:0] w;
    miss = !(c_valid && c_tag == a[20:3]);
    @(negedge clk);
    addr = a;
    rd = 1;
    we = 0;
    w = sh_get(a[20:3]);
    exp_q.push_back(w[{a[2:0], 3'b000} +: 8]);
    r0 = rd_cmds;
    #1;
    check("rd_rdy_drop", ready, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    check("rd_timeout", n < 50, 1);
    check("rd_dout", dout, exp_q.pop_front());
    check("rd_cmds", rd_cmds - r0, miss);
    if (miss) check("rd_addr", rd_word, {8'h30, 3'b000, a[20:3]});
    else check("hit_lat", n, 1);
    c_valid = 1;
    c_tag = a[20:3];
    rd = 0;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [7:0] d,
                          input int b, input bit both);
    int wc;
    int n;
    int r0;
    int w0;
    bit seen;
    logic [28:0] xa;
    logic [7:0]  xbe;
    logic [63:0] xdin;
    logic [63:0] w;
    @(negedge clk);
    addr = a;
    din = d;
    we = 1;
    rd = both;
    wr_q.push_back({{8'h30, 3'b000, a[20:3]}, 8'd1 << a[2:0], {8{d}}});
    w = sh_get(a[20:3]);
    w[{a[2:0], 3'b000} +: 8] = d;
    shadow[int'(a[20:3])] = w;
    r0 = rd_cmds;
    w0 = wr_cmds;
    wc = 0;
    n = 0;
    seen = 0;
    #1;
    check("wr_rdy_drop", ready, 0);
    do begin
      @(negedge clk);
      n++;
      if (DDRAM_WE) begin
        wc++;
        if (!seen) begin
          seen = 1;
          {xa, xbe, xdin} = wr_q.pop_front();
          check("wr_addr", DDRAM_ADDR, xa);
          check("wr_be", DDRAM_BE, xbe);
          check("wr_din", DDRAM_DIN, xdin);
        end
      end
      DDRAM_BUSY = (n <= b);
    end while (!ready && n < 50);
    check("wr_timeout", n < 50, 1);
    check("wr_seen", seen, 1);
    check("wr_we_cycles", wc, b + 1);
    check("wr_cmds", wr_cmds - w0, 1);
    check("wr_no_rd", rd_cmds - r0, 0);
    DDRAM_BUSY = 0;
    we = 0;
    rd = 0;
  endtask

  task automatic reset_mid(input logic [20:0] a);
    @(negedge clk);
    addr = a;
    rd = 1;
    we = 0;
    DDRAM_BUSY = 1;
    @(negedge clk);
    check("rst_rd_pre", DDRAM_RD, 1);
    rst_n = 0;
    rd = 0;
    DDRAM_BUSY = 0;
    #1;
    check("rst_rd", DDRAM_RD, 0);
    check("rst_we", DDRAM_WE, 0);
    check("rst_ready", ready, 1);
    check("rst_dout", dout, 8'hFF);
    @(negedge clk);
    rst_n = 1;
    c_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    addr = 21'h0;
    din = 8'h0;
    rd = 0;
    we = 0;
    DDRAM_BUSY = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_dout", dout, 8'hFF);
    check("reset_rd", DDRAM_RD, 0);
    check("reset_we", DDRAM_WE, 0);
    check("reset_be", DDRAM_BE, 8'h00);
    check("reset_din", DDRAM_DIN, 64'h0);
    check("burstcnt", DDRAM_BURSTCNT, 8'd1);
    rst_n = 1;
    @(negedge clk);

    do_read(21'h00005);
    check("first_byte", dout, 8'h66);
    do_read(21'h00002);
    check("hit_byte", dout, 8'h33);
    do_write(21'h00003, 8'hAB, 2, 0);
    do_read(21'h00003);
    check("wr_hit_byte", dout, 8'hAB);
    do_write(21'h00006, 8'h5C, 0, 1);
    do_read(21'h00006);
    do_read(21'h1FFFFF);

    reset_mid(21'h00010);
    do_read(21'h00010);
    do_read(21'h00002);
    do_write(21'h00011, 8'hE7, 1, 0);
    do_read(21'h00011);
    do_read(21'h00010);

    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 2)
        do_write(21'($urandom_range(0, 31)), 8'($urandom), i % 2, 0);
      else
        do_read(21'($urandom_range(0, 31)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
